// File: rtl/an_decode_seq.sv
// Bit-serial decoder for the A=13 unidirectional single-error AN code.
// Residue, correction and division run one bit per cycle behind valid/ready handshakes.
module an_decode_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] ANe,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  Nc,
    output logic        err_det,
    output logic        err_fail,
    output logic [3:0]  err_pos
);

    localparam logic [4:0]  A_MOD = 5'd13;
    localparam logic [11:0] N_MAX = 12'd252;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RES  = 3'd1;
    localparam logic [2:0] CORR = 3'd2;
    localparam logic [2:0] DIV  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic [11:0] word;
    logic [3:0]  r;
    logic [11:0] quot;
    logic [3:0]  rem;
    logic        det_p;
    logic        fail_p;
    logic [3:0]  pos_p;

    logic [4:0]  r_dbl;
    logic [4:0]  r_sub;
    logic [3:0]  r_next;
    logic [4:0]  rem_dbl;
    logic [4:0]  rem_sub;
    logic        rem_ge;
    logic [3:0]  rem_next;
    logic [3:0]  corr_pos;
    logic [15:0] word_ext;
    logic        corr_bit;
    logic [11:0] corr_mask;
    logic        div_fail;

    // 2^i mod 13 is a bijection from 0..11 onto 1..12; this is its inverse.
    function automatic logic [3:0] res_to_pos(input logic [3:0] res);
        case (res)
            4'd1:    return 4'd0;
            4'd2:    return 4'd1;
            4'd4:    return 4'd2;
            4'd8:    return 4'd3;
            4'd3:    return 4'd4;
            4'd6:    return 4'd5;
            4'd12:   return 4'd6;
            4'd11:   return 4'd7;
            4'd9:    return 4'd8;
            4'd5:    return 4'd9;
            4'd10:   return 4'd10;
            4'd7:    return 4'd11;
            default: return 4'hF;
        endcase
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        r_dbl     = {r, word[11]};
        r_sub     = r_dbl - A_MOD;
        r_next    = (r_dbl >= A_MOD) ? r_sub[3:0] : r_dbl[3:0];
        rem_dbl   = {rem, word[11]};
        rem_sub   = rem_dbl - A_MOD;
        rem_ge    = (rem_dbl >= A_MOD);
        rem_next  = rem_ge ? rem_sub[3:0] : rem_dbl[3:0];
        corr_pos  = res_to_pos(r);
        word_ext  = {4'b0000, word};
        corr_bit  = word_ext[corr_pos];
        corr_mask = 12'd1 << corr_pos;
        div_fail  = fail_p | (rem != 4'd0) | (quot > N_MAX);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            word     <= 12'd0;
            r        <= 4'd0;
            quot     <= 12'd0;
            rem      <= 4'd0;
            det_p    <= 1'b0;
            fail_p   <= 1'b0;
            pos_p    <= 4'hF;
            Nc       <= 8'd0;
            err_det  <= 1'b0;
            err_fail <= 1'b0;
            err_pos  <= 4'hF;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word  <= ANe;
                        r     <= 4'd0;
                        cnt   <= 4'd0;
                        state <= RES;
                    end
                end
                RES: begin
                    // Rotating leaves word equal to the received codeword after 12 steps.
                    r    <= r_next;
                    word <= {word[10:0], word[11]};
                    if (cnt == 4'd11) begin
                        cnt   <= 4'd0;
                        state <= CORR;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CORR: begin
                    det_p  <= 1'b0;
                    fail_p <= 1'b0;
                    pos_p  <= 4'hF;
                    if (r != 4'd0) begin
                        det_p <= 1'b1;
                        if (corr_bit) begin
                            word  <= word - corr_mask;
                            pos_p <= corr_pos;
                        end else begin
                            fail_p <= 1'b1;
                        end
                    end
                    quot  <= 12'd0;
                    rem   <= 4'd0;
                    cnt   <= 4'd0;
                    state <= DIV;
                end
                DIV: begin
                    // Twelve restoring steps, then one edge to publish the result.
                    if (cnt == 4'd12) begin
                        err_det  <= det_p;
                        err_pos  <= pos_p;
                        err_fail <= div_fail;
                        Nc       <= div_fail ? 8'd0 : quot[7:0];
                        cnt      <= 4'd0;
                        state    <= DONE;
                    end else begin
                        rem  <= rem_next;
                        quot <= {quot[10:0], rem_ge};
                        word <= {word[10:0], 1'b0};
                        cnt  <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_an_decode_seq.sv
// Self-checking bench for an_decode_seq: directed spec cases, back-pressure,
// mid-operation reset and random words checked against an arithmetic model.
module tb_an_decode_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] ANe;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  Nc;
    logic        err_det;
    logic        err_fail;
    logic [3:0]  err_pos;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] nc;
        logic       det;
        logic       fail;
        logic [3:0] pos;
    } res_t;

    an_decode_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ANe       (ANe),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Nc        (Nc),
        .err_det   (err_det),
        .err_fail  (err_fail),
        .err_pos   (err_pos)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Decoding from the code's definition: find the single 0->1 flip whose weight
    // matches the residue, remove it, and divide by 13.
    function automatic res_t model(input logic [11:0] a);
        res_t e;
        int   w;
        int   res;
        w     = int'(a);
        res   = w % 13;
        e.det = 1'b0;
        e.fail = 1'b0;
        e.pos = 4'hF;
        if (res != 0) begin
            e.det = 1'b1;
            for (int i = 0; i < 12; i++) begin
                if (((1 << i) % 13) == res) begin
                    if (a[i]) begin
                        w     = int'(a) - (1 << i);
                        e.pos = 4'(i);
                    end else begin
                        e.fail = 1'b1;
                    end
                end
            end
        end
        if ((w % 13) != 0 || (w / 13) > 252) e.fail = 1'b1;
        e.nc = e.fail ? 8'd0 : 8'(w / 13);
        return e;
    endfunction

    task automatic check_outputs(input string tag, input res_t e);
        check({tag, " Nc"}, 32'(Nc), 32'(e.nc));
        check({tag, " err_det"}, 32'(err_det), 32'(e.det));
        check({tag, " err_fail"}, 32'(err_fail), 32'(e.fail));
        check({tag, " err_pos"}, 32'(err_pos), 32'(e.pos));
    endtask

    task automatic check_reset(input string tag);
        res_t z;
        z = '{nc: 8'd0, det: 1'b0, fail: 1'b0, pos: 4'hF};
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check_outputs(tag, z);
    endtask

    // Called just after the negedge following the accept edge.
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_word(input string tag, input logic [11:0] a, input res_t e);
        int lat;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        ANe      = a;
        @(negedge clk);
        in_valid = 1'b0;
        ANe      = 12'($urandom);
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        wait_out(lat);
        check({tag, " latency"}, 32'(lat), 32'd26);
        check_outputs(tag, e);
        @(negedge clk);
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic reset_mid(input string tag, input logic [11:0] a, input int k);
        int seen;
        in_valid = 1'b1;
        ANe      = a;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (k - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset(tag);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        check({tag, " no output after reset"}, 32'(seen), 32'd0);
    endtask

    initial begin
        res_t e;
        res_t clean;
        int   lat;
        logic [11:0] a;

        clean    = '{nc: 8'd252, det: 1'b0, fail: 1'b0, pos: 4'hF};
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ANe      = 12'd0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with hand-derived expectations.
        run_word("clean3276", 12'd3276, clean);
        run_word("e3277", 12'd3277, '{nc: 8'd252, det: 1'b1, fail: 1'b0, pos: 4'd0});
        run_word("e3278", 12'd3278, '{nc: 8'd252, det: 1'b1, fail: 1'b0, pos: 4'd1});
        run_word("e3292", 12'd3292, '{nc: 8'd252, det: 1'b1, fail: 1'b0, pos: 4'd4});
        run_word("e3308", 12'd3308, '{nc: 8'd252, det: 1'b1, fail: 1'b0, pos: 4'd5});
        run_word("e3532", 12'd3532, '{nc: 8'd252, det: 1'b1, fail: 1'b0, pos: 4'd8});
        run_word("e3788", 12'd3788, '{nc: 8'd252, det: 1'b1, fail: 1'b0, pos: 4'd9});
        run_word("bad14", 12'd14, '{nc: 8'd0, det: 1'b1, fail: 1'b1, pos: 4'hF});
        run_word("range4095", 12'd4095, '{nc: 8'd0, det: 1'b0, fail: 1'b1, pos: 4'hF});

        // Back-pressure: DONE holds, a new offer is refused until IDLE.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ANe       = 12'd3277;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check("bp latency", 32'(lat), 32'd26);
        e = '{nc: 8'd252, det: 1'b1, fail: 1'b0, pos: 4'd0};
        check_outputs("bp first", e);
        in_valid = 1'b1;
        ANe      = 12'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp out_valid held", 32'(out_valid), 32'd1);
            check("bp in_ready low", 32'(in_ready), 32'd0);
            check_outputs("bp held", e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp back idle", 32'(in_ready), 32'd1);
        check("bp out_valid off", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("bp reaccept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_out(lat);
        check("bp2 latency", 32'(lat), 32'd26);
        check_outputs("bp2 zero", '{nc: 8'd0, det: 1'b0, fail: 1'b0, pos: 4'hF});
        @(negedge clk);

        // Reset during RES and during DIV, each after a result with nonzero outputs.
        run_word("pre_rst1", 12'd3788, model(12'd3788));
        reset_mid("rst_res", 12'd3308, 5);
        run_word("post_rst1", 12'd3276, clean);
        run_word("pre_rst2", 12'd3532, model(12'd3532));
        reset_mid("rst_div", 12'd3292, 20);
        run_word("post_rst2", 12'd3276, clean);

        // Random words: clean codewords, single 0->1 flips and arbitrary values.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: a = 12'(13 * $urandom_range(0, 252));
                1: begin
                    a = 12'(13 * $urandom_range(0, 252));
                    for (int t = 0; t < 64; t++) begin
                        int b;
                        b = int'($urandom_range(0, 11));
                        if (!a[b]) begin
                            a[b] = 1'b1;
                            break;
                        end
                    end
                end
                default: a = 12'($urandom);
            endcase
            run_word("rand", a, model(a));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
